lut_rev: RTL and testbench

LUT_REV -- requirements
Module: lut_rev

---
 rtl/lut_pkg.sv | 31 +++
 rtl/lut_rev_tbl.sv | 37 +++
 rtl/lut_rev.sv | 119 +++++++++++
 tb/tb_lut_rev.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/lut_pkg.sv
// Shared constants and types for the lut_rev reverse-lookup block.
// Holds table geometry, FSM state encoding and the reset contents of the table.
package lut_pkg;

    localparam int PTR_W = 5;
    localparam int ADR_W = 8;
    localparam int DEPTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        RESP = 2'd2
    } state_e;

    // Entries 0..RST_VALID_N-1 come out of reset valid; the rest hold RST_FILL.
    localparam logic [7:0] RST_ADR0    = 8'd3;
    localparam logic [7:0] RST_ADR1    = 8'd4;
    localparam logic [7:0] RST_ADR2    = 8'd5;
    localparam logic [7:0] RST_FILL    = 8'd255;
    localparam int         RST_VALID_N = 3;

    function automatic logic [7:0] rst_adr(input int idx);
        case (idx)
            0:       return RST_ADR0;
            1:       return RST_ADR1;
            2:       return RST_ADR2;
            default: return RST_FILL;
        endcase
    endfunction

endpackage

// File: rtl/lut_rev_tbl.sv
// Table storage for lut_rev: DEPTH address entries with valid bits, one write
// port and a combinational indexed read that reflects pre-write contents.
module lut_rev_tbl #(
    parameter int PTR_W = lut_pkg::PTR_W,
    parameter int ADR_W = lut_pkg::ADR_W,
    parameter int DEPTH = lut_pkg::DEPTH
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [PTR_W-1:0] wr_ptr,
    input  logic [ADR_W-1:0] wr_adr,
    input  logic [PTR_W-1:0] rd_ptr,
    output logic [ADR_W-1:0] rd_adr,
    output logic             rd_vld
);

    logic [DEPTH-1:0][ADR_W-1:0] ent_adr;
    logic [DEPTH-1:0]            ent_vld;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_adr[i] <= ADR_W'(lut_pkg::rst_adr(i));
                ent_vld[i] <= (i < lut_pkg::RST_VALID_N);
            end
        end else if (wr_en) begin
            ent_adr[wr_ptr] <= wr_adr;
            ent_vld[wr_ptr] <= 1'b1;
        end
    end

    // Read sees the registered contents, so a same-cycle write lands after the compare.
    assign rd_adr = ent_adr[rd_ptr];
    assign rd_vld = ent_vld[rd_ptr];

endmodule

// File: rtl/lut_rev.sv
// Reverse lookup: scans the table one entry per cycle from index 0 and returns
// the lowest valid index whose address matches the captured request.
module lut_rev #(
    parameter int PTR_W = lut_pkg::PTR_W,
    parameter int ADR_W = lut_pkg::ADR_W,
    parameter int DEPTH = lut_pkg::DEPTH
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [PTR_W-1:0] wr_ptr,
    input  logic [ADR_W-1:0] wr_adr,
    input  logic             req_valid,
    input  logic [ADR_W-1:0] req_adr,
    output logic             req_ready,
    output logic             rsp_valid,
    output logic             rsp_hit,
    output logic [PTR_W-1:0] rsp_ptr,
    input  logic             rsp_ready
);

    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);

    lut_pkg::state_e  state, state_nxt;
    logic [PTR_W-1:0] scan_idx, scan_idx_nxt;
    logic [ADR_W-1:0] cap_adr, cap_adr_nxt;
    logic             req_ready_nxt, rsp_valid_nxt, rsp_hit_nxt;
    logic [PTR_W-1:0] rsp_ptr_nxt;
    logic [ADR_W-1:0] rd_adr;
    logic             rd_vld;

    lut_rev_tbl #(
        .PTR_W (PTR_W),
        .ADR_W (ADR_W),
        .DEPTH (DEPTH)
    ) u_tbl (
        .CLK    (CLK),
        .reset  (reset),
        .wr_en  (wr_en),
        .wr_ptr (wr_ptr),
        .wr_adr (wr_adr),
        .rd_ptr (scan_idx),
        .rd_adr (rd_adr),
        .rd_vld (rd_vld)
    );

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state     <= lut_pkg::IDLE;
            scan_idx  <= '0;
            cap_adr   <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_hit   <= 1'b0;
            rsp_ptr   <= '0;
        end else begin
            state     <= state_nxt;
            scan_idx  <= scan_idx_nxt;
            cap_adr   <= cap_adr_nxt;
            req_ready <= req_ready_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_hit   <= rsp_hit_nxt;
            rsp_ptr   <= rsp_ptr_nxt;
        end
    end

    // Outputs are computed one cycle ahead so every port is driven by a flop.
    always_comb begin
        state_nxt     = state;
        scan_idx_nxt  = scan_idx;
        cap_adr_nxt   = cap_adr;
        req_ready_nxt = req_ready;
        rsp_valid_nxt = rsp_valid;
        rsp_hit_nxt   = rsp_hit;
        rsp_ptr_nxt   = rsp_ptr;
        case (state)
            lut_pkg::IDLE: begin
                if (req_valid) begin
                    cap_adr_nxt   = req_adr;
                    scan_idx_nxt  = '0;
                    state_nxt     = lut_pkg::SCAN;
                    req_ready_nxt = 1'b0;
                end
            end
            lut_pkg::SCAN: begin
                if (rd_vld && (rd_adr == cap_adr)) begin
                    state_nxt     = lut_pkg::RESP;
                    rsp_valid_nxt = 1'b1;
                    rsp_hit_nxt   = 1'b1;
                    rsp_ptr_nxt   = scan_idx;
                end else if (scan_idx == LAST_IDX) begin
                    state_nxt     = lut_pkg::RESP;
                    rsp_valid_nxt = 1'b1;
                    rsp_hit_nxt   = 1'b0;
                    rsp_ptr_nxt   = '0;
                end else begin
                    scan_idx_nxt  = scan_idx + 1'b1;
                end
            end
            lut_pkg::RESP: begin
                if (rsp_ready) begin
                    state_nxt     = lut_pkg::IDLE;
                    req_ready_nxt = 1'b1;
                    rsp_valid_nxt = 1'b0;
                    rsp_hit_nxt   = 1'b0;
                    rsp_ptr_nxt   = '0;
                end
            end
            default: begin
                state_nxt     = lut_pkg::IDLE;
                req_ready_nxt = 1'b1;
                rsp_valid_nxt = 1'b0;
                rsp_hit_nxt   = 1'b0;
                rsp_ptr_nxt   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_lut_rev.sv
// Self-checking bench for lut_rev: vector table after reset, hand-written
// corner sequences, then randomized traffic against a linear-search model.
module tb_lut_rev;

    logic       CLK = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [4:0] wr_ptr;
    logic [7:0] wr_adr;
    logic       req_valid;
    logic [7:0] req_adr;
    logic       req_ready;
    logic       rsp_valid;
    logic       rsp_hit;
    logic [4:0] rsp_ptr;
    logic       rsp_ready;

    int nvec = 0;
    int nbad = 0;

    int mdl_adr [32];
    bit mdl_vld [32];

    lut_rev dut (
        .CLK       (CLK),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_ptr    (wr_ptr),
        .wr_adr    (wr_adr),
        .req_valid (req_valid),
        .req_adr   (req_adr),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_hit   (rsp_hit),
        .rsp_ptr   (rsp_ptr),
        .rsp_ready (rsp_ready)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] adr;
        logic       hit;
        logic [4:0] ptr;
        int         lat;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nbad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic mdl_reset();
        for (int i = 0; i < 32; i++) begin
            mdl_adr[i] = (i == 0) ? 3 : (i == 1) ? 4 : (i == 2) ? 5 : 255;
            mdl_vld[i] = (i < 3);
        end
    endtask

    // Lowest valid index holding the address; a miss costs the full 32-entry scan.
    task automatic ref_lookup(input int a, output int h, output int p, output int l);
        h = 0; p = 0; l = 32;
        for (int i = 31; i >= 0; i--)
            if (mdl_vld[i] && mdl_adr[i] == a) begin
                h = 1; p = i; l = i + 1;
            end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_write(input int p, input int a);
        wr_en = 1'b1; wr_ptr = 5'(p); wr_adr = 8'(a);
        tick();
        wr_en = 1'b0;
        mdl_adr[p] = a;
        mdl_vld[p] = 1'b1;
    endtask

    task automatic start_req(input int a);
        req_valid = 1'b1; req_adr = 8'(a);
        tick();
        req_valid = 1'b0;
        req_adr = 8'($urandom);
    endtask

    task automatic wait_rsp(input int lat0, output int lat);
        lat = lat0;
        while (!rsp_valid && lat < 64) begin
            tick();
            lat++;
        end
    endtask

    task automatic finish_rsp(input string name);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check({name, " idle.req_ready"}, int'(req_ready), 1);
        check({name, " idle.rsp_valid"}, int'(rsp_valid), 0);
    endtask

    task automatic run_req(input string name, input int a, input int eh, input int ep, input int el);
        int lat;
        start_req(a);
        wait_rsp(0, lat);
        check({name, " latency"}, lat, el);
        check({name, " hit"}, int'(rsp_hit), eh);
        check({name, " ptr"}, int'(rsp_ptr), ep);
        finish_rsp(name);
    endtask

    vec_t vt [6];

    initial begin
        int lat, h, p, l, a, nw;
        reset = 1'b1; wr_en = 1'b0; wr_ptr = '0; wr_adr = '0;
        req_valid = 1'b0; req_adr = '0; rsp_ready = 1'b0;
        mdl_reset();
        repeat (2) @(posedge CLK);
        #1 reset = 1'b0;

        check("reset req_ready", int'(req_ready), 1);
        check("reset rsp_valid", int'(rsp_valid), 0);
        check("reset rsp_hit",   int'(rsp_hit),   0);
        check("reset rsp_ptr",   int'(rsp_ptr),   0);

        vt[0] = '{8'd5,   1'b1, 5'd2, 3};
        vt[1] = '{8'd3,   1'b1, 5'd0, 1};
        vt[2] = '{8'd4,   1'b1, 5'd1, 2};
        vt[3] = '{8'd200, 1'b0, 5'd0, 32};
        vt[4] = '{8'd255, 1'b0, 5'd0, 32};
        vt[5] = '{8'd0,   1'b0, 5'd0, 32};
        for (int i = 0; i < 6; i++)
            run_req($sformatf("vec%0d", i), vt[i].adr, vt[i].hit, vt[i].ptr, vt[i].lat);

        // Duplicate address resolves to the lower index.
        do_write(7, 64);
        do_write(9, 64);
        run_req("dup64", 64, 1, 7, 8);

        // Held response stays stable; a pending request is taken only after release.
        start_req(5);
        wait_rsp(0, lat);
        check("stall latency", lat, 3);
        req_valid = 1'b1; req_adr = 8'd4;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall rsp_valid", int'(rsp_valid), 1);
            check("stall rsp_hit",   int'(rsp_hit),   1);
            check("stall rsp_ptr",   int'(rsp_ptr),   2);
            check("stall req_ready", int'(req_ready), 0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("release req_ready", int'(req_ready), 1);
        check("release rsp_valid", int'(rsp_valid), 0);
        tick();
        req_valid = 1'b0;
        wait_rsp(0, lat);
        check("after-stall latency", lat, 2);
        check("after-stall ptr", int'(rsp_ptr), 1);
        finish_rsp("after-stall");

        // Reset in the middle of a scan aborts it and restores the table.
        do_write(1, 77);
        start_req(3);
        reset = 1'b1;
        #1;
        check("midscan req_ready", int'(req_ready), 1);
        check("midscan rsp_valid", int'(rsp_valid), 0);
        check("midscan rsp_hit",   int'(rsp_hit),   0);
        check("midscan rsp_ptr",   int'(rsp_ptr),   0);
        @(posedge CLK);
        #1 reset = 1'b0;
        mdl_reset();
        for (int i = 0; i < 4; i++) begin
            tick();
            check("aborted rsp_valid", int'(rsp_valid), 0);
        end
        run_req("restored4", 4, 1, 1, 2);

        // Entry 0 written to 99 in the very cycle it is compared: still a miss.
        start_req(99);
        wr_en = 1'b1; wr_ptr = 5'd0; wr_adr = 8'd99;
        tick();
        wr_en = 1'b0;
        mdl_adr[0] = 99;
        wait_rsp(1, lat);
        check("wrcmp latency", lat, 32);
        check("wrcmp hit", int'(rsp_hit), 0);
        check("wrcmp ptr", int'(rsp_ptr), 0);
        finish_rsp("wrcmp");
        run_req("wrcmp-after", 99, 1, 0, 1);

        for (int it = 0; it < 40; it++) begin
            nw = $urandom_range(0, 3);
            for (int w = 0; w < nw; w++)
                do_write($urandom_range(0, 31), $urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) a = mdl_adr[$urandom_range(0, 31)];
            else a = $urandom_range(0, 20);
            ref_lookup(a, h, p, l);
            run_req($sformatf("rnd%0d adr=%0d", it, a), a, h, p, l);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
